// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA types plus the AXI4-Lite register map of vga_axil_regs
package vga_pkg;
  typedef enum logic [1:0] {
    VGA_RES_800_600   = 2'd0,
    VGA_RES_640_480   = 2'd1,
    VGA_RES_1024_768  = 2'd2,
    VGA_RES_1280_1024 = 2'd3
  } vga_resolution_e;
  localparam int unsigned VGA_RES_NUM = 4;
  localparam logic [10:0] REG_CTRL    = 11'h000;
  localparam logic [10:0] REG_STATUS  = 11'h004;
  localparam logic [10:0] REG_SCRATCH = 11'h008;
  localparam logic [10:0] REG_ID      = 11'h00C;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int CTRL_RES_LSB    = 8;
  localparam int CTRL_RES_W      = 8;
  localparam int CTRL_START_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
endpackage

// File: rtl/vga_axil_skid.sv
// vga_axil_skid: one-deep valid/ready capture buffer for an AXI4-Lite channel
module vga_axil_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         pop
);
  logic full_next;
  assign full_next = (in_valid & in_ready) | (out_valid & ~pop);
  // ready is registered as "empty next cycle" so it stays low through reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready  <= ~full_next;
      out_valid <= full_next;
      if (in_valid & in_ready) out_data <= in_data;
    end
endmodule

// File: rtl/vga_axil_regs.sv
// vga_axil_regs: AXI4-Lite control/status registers driving vga_clk_gen
module vga_axil_regs
  import vga_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5647_4101
) (
  input  logic            clk_100m_i,
  input  logic            arstn_i,
  input  logic [10:0]     s_axi_awaddr,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [31:0]     s_axi_wdata,
  input  logic [3:0]      s_axi_wstrb,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [10:0]     s_axi_araddr,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  output vga_resolution_e resolution_o,
  output logic            req_o,
  input  logic            valid_i
);
  logic        aw_full, w_full, commit, busy, done;
  logic [8:0]  wsel;
  logic [35:0] w_buf;
  logic [31:0] wd, scratch, rd_data;
  logic [3:0]  ws;
  logic [7:0]  new_res;
  logic        start, known, ctrl_en, ctrl_bad, ctrl_go, w1c, scr_en, ar_hs, rvalid_next;
  logic [1:0]  wr_resp, rd_resp;
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  vga_axil_skid #(.W(9)) u_aw (
    .clk(clk_100m_i), .rst_n(arstn_i), .in_data(s_axi_awaddr[10:2]), .in_valid(s_axi_awvalid),
    .in_ready(s_axi_awready), .out_data(wsel), .out_valid(aw_full), .pop(commit)
  );
  vga_axil_skid #(.W(36)) u_w (
    .clk(clk_100m_i), .rst_n(arstn_i), .in_data({s_axi_wstrb, s_axi_wdata}), .in_valid(s_axi_wvalid),
    .in_ready(s_axi_wready), .out_data(w_buf), .out_valid(w_full), .pop(commit)
  );

  assign commit   = aw_full & w_full & ~s_axi_bvalid;
  assign wd       = w_buf[31:0];
  assign ws       = w_buf[35:32];
  assign new_res  = wd[CTRL_RES_LSB +: CTRL_RES_W];
  assign start    = wd[CTRL_START_BIT];
  assign known    = wsel inside {REG_CTRL[10:2], REG_STATUS[10:2], REG_SCRATCH[10:2], REG_ID[10:2]};
  assign ctrl_en  = commit && wsel == REG_CTRL[10:2] && &ws[1:0];
  assign ctrl_bad = 32'(new_res) >= VGA_RES_NUM || (busy && start);
  assign ctrl_go  = ctrl_en && !ctrl_bad;
  assign w1c      = commit && wsel == REG_STATUS[10:2] && ws[0] && wd[STATUS_DONE_BIT];
  assign scr_en   = commit && wsel == REG_SCRATCH[10:2];
  assign wr_resp  = (!known || (ctrl_en && ctrl_bad)) ? RESP_SLVERR : RESP_OKAY;

  // read decode from the live AR address; only sampled on the AR handshake
  always_comb begin
    rd_resp = RESP_OKAY;
    rd_data = '0;
    case (s_axi_araddr[10:2])
      REG_CTRL[10:2]:    rd_data[CTRL_RES_LSB +: CTRL_RES_W] = 8'(resolution_o);
      REG_STATUS[10:2]:  rd_data[STATUS_DONE_BIT:STATUS_BUSY_BIT] = {done, busy};
      REG_SCRATCH[10:2]: rd_data = scratch;
      REG_ID[10:2]:      rd_data = ID_VALUE;
      default:           rd_resp = RESP_SLVERR;
    endcase
  end

  // register state updated by write commits and completion pulses; a new START outranks valid_i, which outranks W1C
  always_ff @(posedge clk_100m_i or negedge arstn_i)
    if (!arstn_i) begin
      resolution_o <= VGA_RES_800_600;
      req_o        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      scratch      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      req_o <= ctrl_go && start;
      if (ctrl_go) resolution_o <= vga_resolution_e'(new_res[1:0]);
      if (ctrl_go && start) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (valid_i) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else if (w1c) done <= 1'b0;
      if (scr_en) for (int i = 0; i < 4; i++) if (ws[i]) scratch[8*i +: 8] <= wd[8*i +: 8];
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
    end

  assign ar_hs       = s_axi_arvalid & s_axi_arready;
  assign rvalid_next = ar_hs | (s_axi_rvalid & ~s_axi_rready);

  // read channel: capture data on AR handshake and hold it until rready
  always_ff @(posedge clk_100m_i or negedge arstn_i)
    if (!arstn_i) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= ~rvalid_next;
      s_axi_rvalid  <= rvalid_next;
      if (ar_hs) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_resp;
      end
    end
endmodule

// File: tb/tb_vga_axil_regs.sv
// tb_vga_axil_regs: random AXI4-Lite traffic against a register-level model plus directed corner cases
module tb_vga_axil_regs;
  import vga_pkg::*;
  typedef struct {logic [10:0] a; logic [31:0] d; logic [3:0] s;} wr_t;

  logic clk = 1'b0, arstn = 1'b0;
  logic [10:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0, valid_i = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, req_o;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  vga_resolution_e resolution_o;

  vga_axil_regs dut (
    .clk_100m_i(clk), .arstn_i(arstn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .resolution_o(resolution_o), .req_o(req_o), .valid_i(valid_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, req_cnt = 0;
  wr_t wq[$];
  logic [31:0] rq_d[$];
  logic [1:0] rq_r[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // register-level model: what the host should see, from the register map rules
  logic [7:0] m_res = '0, m_scr[4];
  logic m_busy = 1'b0, m_done = 1'b0, prev_b = 1'b0, prev_r = 1'b0, vi_prev = 1'b0, exp_req;
  logic [1:0] cur_b = '0, cur_rr = '0, pr;
  logic [31:0] cur_rd = '0, pd;
  int since_rst = 0;
  wr_t w;

  always begin
    @(negedge clk);
    #2;
    if (req_o) req_cnt++;
    if (!arstn) begin
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_req", 32'(req_o), 0);
      chk("rst_readies", 32'({awready, wready, arready}), 0);
      chk("rst_resolution", 32'(resolution_o), 0);
      m_res = '0; m_busy = 1'b0; m_done = 1'b0;
      for (int i = 0; i < 4; i++) m_scr[i] = '0;
      wq.delete(); rq_d.delete(); rq_r.delete();
      prev_b = 1'b0; prev_r = 1'b0; vi_prev = 1'b0; since_rst = 0;
    end else begin
      exp_req = 1'b0;
      if (bvalid && !prev_b) begin
        if (wq.size() == 0) chk("unexpected_bvalid", 1, 0);
        else begin
          w = wq.pop_front();
          cur_b = 2'b00;
          case (w.a[10:2])
            9'h0: if (w.s[1:0] == 2'b11) begin
                    if (w.d[15:8] >= 8'd4 || (m_busy && w.d[0])) cur_b = 2'b10;
                    else begin
                      m_res = w.d[15:8];
                      if (w.d[0]) begin m_busy = 1'b1; m_done = 1'b0; exp_req = 1'b1; end
                    end
                  end
            9'h1: if (w.s[0] && w.d[1] && !vi_prev) m_done = 1'b0;
            9'h2: for (int i = 0; i < 4; i++) if (w.s[i]) m_scr[i] = w.d[8*i +: 8];
            9'h3: ;
            default: cur_b = 2'b10;
          endcase
        end
      end
      if (bvalid) chk("bresp", 32'(bresp), 32'(cur_b));
      chk("req", 32'(req_o), 32'(exp_req));
      chk("resolution", 32'(resolution_o), 32'(m_res));
      if (since_rst > 0) chk("arready_vs_rvalid", 32'(arready), 32'(!rvalid));
      if (rvalid && !prev_r) begin
        if (rq_d.size() == 0) chk("unexpected_rvalid", 1, 0);
        else begin cur_rd = rq_d.pop_front(); cur_rr = rq_r.pop_front(); end
      end
      if (rvalid) begin
        chk("rdata", rdata, cur_rd);
        chk("rresp", 32'(rresp), 32'(cur_rr));
      end
      if (arvalid && arready) begin
        pr = 2'b00;
        case (araddr[10:2])
          9'h0: pd = {16'h0, m_res, 8'h0};
          9'h1: pd = {30'h0, m_done, m_busy};
          9'h2: pd = {m_scr[3], m_scr[2], m_scr[1], m_scr[0]};
          9'h3: pd = 32'h5647_4101;
          default: begin pd = 32'h0; pr = 2'b10; end
        endcase
        rq_d.push_back(pd);
        rq_r.push_back(pr);
      end
      if (valid_i) begin m_busy = 1'b0; m_done = 1'b1; end
      vi_prev = valid_i;
      prev_b = bvalid;
      prev_r = rvalid;
      since_rst++;
    end
  end

  task automatic send_aw(input logic [10:0] a);
    @(negedge clk); awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 200 && !awready; i++) @(negedge clk);
    if (!awready) chk("aw_timeout", 0, 1);
    @(negedge clk); awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 200 && !wready; i++) @(negedge clk);
    if (!wready) chk("w_timeout", 0, 1);
    @(negedge clk); wvalid = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] r, input int dly);
    repeat (dly) @(negedge clk);
    @(negedge clk); bready = 1'b1;
    for (int i = 0; i < 200 && !bvalid; i++) @(negedge clk);
    if (!bvalid) chk("b_timeout", 0, 1);
    r = bresp;
    @(negedge clk); bready = 1'b0;
  endtask

  task automatic send_ar(input logic [10:0] a);
    @(negedge clk); araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 200 && !arready; i++) @(negedge clk);
    if (!arready) chk("ar_timeout", 0, 1);
    @(negedge clk); arvalid = 1'b0;
  endtask

  task automatic recv_r(output logic [31:0] d, output logic [1:0] r, input int dly);
    repeat (dly) @(negedge clk);
    rready = 1'b1;
    for (int i = 0; i < 200 && !rvalid; i++) @(negedge clk);
    if (!rvalid) chk("r_timeout", 0, 1);
    d = rdata; r = rresp;
    @(negedge clk); rready = 1'b0;
  endtask

  task automatic axi_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wdl, input int bd, output logic [1:0] r);
    wq.push_back('{a, d, s});
    fork
      begin repeat (awd) @(negedge clk); send_aw(a); end
      begin repeat (wdl) @(negedge clk); send_w(d, s); end
    join
    recv_b(r, bd);
  endtask

  task automatic axi_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] r, input int rd);
    send_ar(a);
    recv_r(d, r, rd);
  endtask

  task automatic pulse_valid();
    @(negedge clk); valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] r;
  logic [31:0] d, rd2;
  int r0;
  logic [10:0] addrs [6];

  initial begin
    addrs = '{REG_CTRL, REG_STATUS, REG_SCRATCH, REG_ID, 11'h010, 11'h3F0};
    repeat (3) @(negedge clk);
    chk("ready_low_in_reset", 32'({awready, wready, arready}), 0);
    @(posedge clk); #2 arstn = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", 32'({awready, wready, arready}), 0);
    @(negedge clk);
    chk("ready_after_first_edge", 32'({awready, wready, arready}), 32'h7);

    axi_read(REG_ID, d, r, 0);
    chk("id_rdata", d, 32'h5647_4101);
    chk("id_rresp", 32'(r), 0);
    axi_read(REG_STATUS, d, r, 0);
    chk("status_reset", d, 0);

    r0 = req_cnt;
    axi_write(REG_CTRL, 32'h0000_0101, 4'hF, 0, 1, 0, r);
    chk("ctrl_start_bresp", 32'(r), 0);
    chk("ctrl_start_res", 32'(resolution_o), 1);
    chk("ctrl_start_req_count", 32'(req_cnt - r0), 1);
    axi_read(REG_STATUS, d, r, 0);
    chk("status_busy", d, 32'h1);

    r0 = req_cnt;
    axi_write(REG_CTRL, 32'h0000_0201, 4'hF, 0, 0, 0, r);
    chk("start_while_busy_bresp", 32'(r), 32'h2);
    chk("start_while_busy_res", 32'(resolution_o), 1);
    chk("start_while_busy_no_req", 32'(req_cnt - r0), 0);

    fork
      axi_read(REG_STATUS, d, r, 0);
      pulse_valid();
    join
    chk("status_read_same_cycle_valid", d, 32'h1);
    axi_read(REG_STATUS, d, r, 0);
    chk("status_done", d, 32'h2);

    fork
      axi_write(REG_STATUS, 32'h2, 4'hF, 0, 0, 0, r);
      begin @(negedge clk); pulse_valid(); end
    join
    axi_read(REG_STATUS, d, r, 0);
    chk("done_set_wins_over_w1c", d, 32'h2);
    axi_write(REG_STATUS, 32'h2, 4'hF, 0, 0, 0, r);
    axi_read(REG_STATUS, d, r, 0);
    chk("done_w1c", d, 32'h0);

    axi_write(REG_CTRL, 32'h0000_0400, 4'hF, 0, 0, 0, r);
    chk("res_num_slverr", 32'(r), 32'h2);
    axi_read(11'h010, d, r, 0);
    chk("unmapped_rdata", d, 0);
    chk("unmapped_rresp", 32'(r), 32'h2);
    r0 = req_cnt;
    axi_write(REG_CTRL, 32'h0000_0301, 4'b0001, 0, 0, 0, r);
    chk("ctrl_partial_strb_okay", 32'(r), 0);
    chk("ctrl_partial_strb_res", 32'(resolution_o), 1);
    chk("ctrl_partial_strb_no_req", 32'(req_cnt - r0), 0);

    axi_write(REG_SCRATCH, 32'hA5A5_A5A5, 4'hF, 1, 0, 0, r);
    axi_write(REG_SCRATCH, 32'h1234_5678, 4'b0101, 0, 2, 1, r);
    axi_read(REG_SCRATCH, d, r, 0);
    chk("scratch_strobes", d, 32'hA534_A578);

    wq.push_back('{REG_SCRATCH, 32'h1111_1111, 4'hF});
    fork send_aw(REG_SCRATCH); send_w(32'h1111_1111, 4'hF); join
    wq.push_back('{REG_SCRATCH, 32'h2222_2222, 4'hF});
    fork send_aw(REG_SCRATCH); send_w(32'h2222_2222, 4'hF); join
    repeat (5) begin
      @(negedge clk);
      chk("hold_bvalid", 32'(bvalid), 1);
      chk("hold_bresp", 32'(bresp), 0);
      chk("hold_no_aw_w_accept", 32'({awready, wready}), 0);
    end
    recv_b(r, 0);
    recv_b(r, 0);
    send_ar(REG_ID);
    repeat (5) begin
      @(negedge clk);
      chk("hold_rvalid", 32'(rvalid), 1);
      chk("hold_rdata", rdata, 32'h5647_4101);
      chk("hold_no_ar_accept", 32'(arready), 0);
    end
    recv_r(d, r, 0);
    axi_read(REG_SCRATCH, d, r, 0);
    chk("scratch_second_write", d, 32'h2222_2222);

    for (int n = 0; n < 300; n++) begin
      int op;
      logic [10:0] a, ra;
      logic [31:0] wdv;
      logic [3:0] s;
      op = $urandom_range(0, 9);
      a = addrs[$urandom_range(0, 5)] | 11'($urandom_range(0, 3));
      ra = addrs[$urandom_range(0, 5)] | 11'($urandom_range(0, 3));
      wdv = $urandom;
      wdv[15:8] = 8'($urandom_range(0, 5));
      s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      if (op <= 4) axi_write(a, wdv, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
      else if (op <= 7) axi_read(ra, d, r, $urandom_range(0, 3));
      else if (op == 8) pulse_valid();
      else fork
        axi_write(a, wdv, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r);
        axi_read(ra, rd2, r, $urandom_range(0, 2));
      join
    end

    axi_write(REG_CTRL, 32'h0000_0300, 4'hF, 0, 0, 0, r);
    if (m_busy) pulse_valid();
    r0 = req_cnt;
    send_aw(REG_CTRL);
    send_w(32'h0000_0101, 4'hF);
    #1 arstn = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 arstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_mid_write_no_req", 32'(req_cnt - r0), 0);
    chk("reset_mid_write_no_bvalid", 32'(bvalid), 0);
    chk("reset_mid_write_resolution", 32'(resolution_o), 0);
    axi_read(REG_STATUS, d, r, 0);
    chk("reset_mid_write_status", d, 0);

    repeat (3) @(negedge clk);
    chk("write_queue_drained", 32'(wq.size()), 0);
    chk("read_queue_drained", 32'(rq_d.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
